rom_stream_reader: RTL and testbench

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

---
 rtl/rom_stream_reader.sv | 112 +++++++++++
 tb/tb_rom_stream_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Streams a burst of consecutive words out of an async-read ROM onto a
// registered valid/ready output; one word per cycle when not stalled.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  // Handshake: a word moves when out_valid && out_ready at a rising edge;
  // while out_valid is high and out_ready low, out_data/out_last/out_valid hold.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  accept;
  logic                  zero_req;
  logic                  load;
  logic                  xfer;
  logic                  last_xfer;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    zero_req  = 1'b0;
    load      = 1'b0;
    last_xfer = 1'b0;
    xfer      = out_valid && out_ready;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept  = 1'b1;
            state_n = RUN;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      RUN: begin
        // The output register refills whenever it is empty or being drained.
        load = !out_valid || out_ready;
        if (load && remaining == REM_ONE) state_n = DRAIN;
      end
      DRAIN: begin
        if (xfer) begin
          last_xfer = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= zero_req || last_xfer;
      if (accept) begin
        addr_q    <= start_addr;
        remaining <= length;
      end
      if (load) begin
        out_data  <= rom_data;
        out_valid <= 1'b1;
        out_last  <= (remaining == REM_ONE);
        addr_q    <= addr_q + ADDR_WIDTH'(1);
        remaining <= remaining - REM_ONE;
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign rom_addr  = addr_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: queue-based word model, per-cycle compare at
// the falling edge, directed bursts with literal pins plus random bursts.
module tb_rom_stream_reader;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  logic [DW-1:0] rom [0:255];
  assign rom_data = rom[rom_addr];

  rom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // scoreboard state: each entry is {last, data}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] log_q[16];
  int total = 0;
  int bad = 0;
  int burst_n;
  bit zero_due;
  bit done_flag;
  int ready_mode;
  int pat_idx;
  int pat[6] = '{1, 0, 0, 1, 0, 1};
  logic          p_valid, p_ready, p_last, p_rst;
  logic [DW-1:0] p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare against the model, run at the falling edge after each rising edge
  task automatic check();
    logic [W-1:0] e;
    bit exp_done;
    if (p_rst) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", rom_addr, 0);
      exp_q.delete();
      zero_due = 0;
    end else begin
      exp_done = zero_due;
      zero_due = 0;
      if (p_valid && p_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", p_data, e[DW-1:0]);
          chk("last", p_last, e[DW]);
          if (burst_n < 16) log_q[burst_n] = {p_last, p_data};
          burst_n++;
          if (e[DW]) exp_done = 1;
          if (ready_mode == 0 && !e[DW]) chk("no_bubble", out_valid, 1);
        end
      end else if (p_valid) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, p_data);
        chk("stall_last", out_last, p_last);
      end
      chk("done", done, exp_done);
      if (done) begin
        chk("done_vs_valid", out_valid, 0);
        chk("done_busy", busy, 0);
        done_flag = 1;
      end
    end
  endtask

  task automatic cycle();
    p_valid = out_valid;
    p_ready = out_ready;
    p_data  = out_data;
    p_last  = out_last;
    p_rst   = rst;
    @(posedge clk);
    @(negedge clk);
    check();
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin out_ready = 1'(pat[pat_idx % 6]); pat_idx++; end
    endcase
  endtask

  // driver: issue a burst, push its expected words, wait for completion
  task automatic run_burst(input logic [AW-1:0] sa, input int len, input int mode, input bit poke);
    int n;
    ready_mode = mode;
    pat_idx    = 0;
    out_ready  = (mode == 2) ? 1'b1 : (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
    if (mode == 2) pat_idx = 1;
    burst_n    = 0;
    done_flag  = 0;
    start      = 1'b1;
    start_addr = sa;
    length     = 9'(len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), rom[8'((int'(sa) + i) % 256)]});
    zero_due = (len == 0);
    cycle();
    start      = 1'b0;
    start_addr = 8'($urandom);
    length     = 9'($urandom);
    if (len > 0) begin
      chk("lat_busy", busy, 1);
      chk("lat_valid_early", out_valid, 0);
      cycle();
      chk("lat_valid", out_valid, 1);
    end else begin
      chk("zero_busy", busy, 0);
      chk("zero_valid", out_valid, 0);
    end
    n = 0;
    while (!(exp_q.size() == 0 && done_flag) && n < 3000) begin
      if (poke && n == 2) begin
        start      = 1'b1;
        start_addr = sa + 8'h40;
        length     = 9'd5;
      end else begin
        start = 1'b0;
      end
      cycle();
      n++;
    end
    start = 1'b0;
    if (n >= 3000) chk("burst_timeout", 1, 0);
    chk("end_addr", rom_addr, (len == 0) ? 32'(rom_addr_before_zero) : 32'((int'(sa) + len) % 256));
    chk("end_busy", busy, 0);
    cycle();
  endtask

  logic [AW-1:0] rom_addr_before_zero;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b1;
    ready_mode = 0;
    burst_n    = 0;
    zero_due   = 0;
    done_flag  = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 7 + 3) % 256);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // plain burst with literal pins on the model
    rom_addr_before_zero = rom_addr;
    run_burst(8'h10, 4, 0, 0);
    chk("pin_w0", log_q[0], 9'h073);
    chk("pin_w1", log_q[1], 9'h07A);
    chk("pin_w2", log_q[2], 9'h081);
    chk("pin_w3", log_q[3], 9'h188);
    chk("pin_count", burst_n, 4);

    // address wrap
    run_burst(8'hFE, 4, 0, 0);
    chk("wrap_w0", log_q[0], 9'h0F5);
    chk("wrap_w1", log_q[1], 9'h0FC);
    chk("wrap_w2", log_q[2], 9'h003);
    chk("wrap_w3", log_q[3], 9'h10A);

    // backpressure pattern 1,0,0,1,0,1,...
    run_burst(8'h20, 3, 2, 0);
    chk("bp_count", burst_n, 3);

    // zero length: done only, rom_addr untouched
    rom_addr_before_zero = rom_addr;
    run_burst(8'h55, 0, 0, 0);
    chk("zero_count", burst_n, 0);

    // start during RUN is ignored
    run_burst(8'h80, 12, 0, 1);
    chk("poke_count", burst_n, 12);

    // reset after two of eight words
    ready_mode = 0;
    out_ready  = 1'b1;
    burst_n    = 0;
    start      = 1'b1;
    start_addr = 8'h30;
    length     = 9'd8;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), rom[8'(8'h30 + i)]});
    cycle();
    start = 1'b0;
    for (int n = 0; n < 50 && burst_n < 2; n++) cycle();
    chk("pre_rst_words", burst_n, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_words", burst_n, 2);
    rom_addr_before_zero = rom_addr;
    run_burst(8'h30, 5, 1, 0);
    chk("after_rst_count", burst_n, 5);

    // random ROM contents and random bursts
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int b = 0; b < 14; b++) begin
      int l;
      l = $urandom_range(0, 20);
      rom_addr_before_zero = rom_addr;
      run_burst(8'($urandom), l, $urandom_range(0, 2), 0);
      chk("rand_count", burst_n, l);
    end

    // full sweep of the ROM
    rom_addr_before_zero = rom_addr;
    run_burst(8'h9C, 256, 1, 0);
    chk("full_count", burst_n, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
